trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: inst_i  input  32  instruction currently in decode.
REQ-004 SHALL: inst_addr_i  input  64  PC of inst_i.
REQ-005 SHALL: inst_valid_i  input  1  inst_i/inst_addr_i hold a real instruction this cycle.
REQ-006 SHALL: irq_timer_i  input  1  level-sensitive machine timer interrupt request.
REQ-007 SHALL: mstatus_i, mtvec_i, mepc_i, mie_i  input  64 each  current CSR values.
REQ-008 SHALL: csr_we_o  output  1  CSR write strobe.
REQ-009 SHALL: csr_waddr_o  output  12  CSR write address.
REQ-010 SHALL: csr_wdata_o  output  64  CSR write data.
REQ-011 SHALL: hold_o  output  1  pipeline stall request to ctrl.
REQ-012 SHALL: jump_en_o  output  1  one-cycle redirect strobe.
REQ-013 SHALL: jump_addr_o  output  64  redirect target, valid when jump_en_o=1.

Function
REQ-014 SHALL: FSM states IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, JUMP; one CSR write per cycle through the single write port.
REQ-015 SHALL: in IDLE with inst_valid_i=1 and inst_i=ECALL (0x00000073), capture pc=inst_addr_i, cause=64'd11, mstatus snapshot, target={mtvec_i[63:2],2'b00}; next state WR_MEPC.
REQ-016 SHALL: in IDLE with inst_valid_i=1 and inst_i=MRET (0x30200073), capture mstatus snapshot, target=mepc_i; next state WR_MSTATUS.
REQ-017 SHALL: in IDLE, when no ECALL/MRET is present and irq_timer_i & mstatus_i[3] & mie_i[7] & inst_valid_i, capture pc=inst_addr_i (instruction not executed), cause=0x8000_0000_0000_0007, mstatus snapshot, target as REQ-015; next state WR_MEPC.
REQ-018 SHALL: ECALL/MRET take priority over a simultaneous interrupt; the interrupt is not latched and is re-evaluated on return to IDLE.
REQ-019 SHALL: WR_MEPC drives csr_we_o=1, addr 0x341, data=pc; next WR_MCAUSE.
REQ-020 SHALL: WR_MCAUSE drives csr_we_o=1, addr 0x342, data=cause; next WR_MSTATUS.
REQ-021 SHALL: WR_MSTATUS (trap) drives addr 0x300, data=snapshot with bit7 (MPIE) = snapshot[3], bit3 (MIE) = 0, other bits unchanged.
REQ-022 SHALL: WR_MSTATUS (MRET) drives addr 0x300, data=snapshot with bit3 = snapshot[7], bit7 = 1, other bits unchanged.
REQ-023 SHALL: WR_MSTATUS always proceeds to JUMP; JUMP drives jump_en_o=1, jump_addr_o=target for exactly one cycle, then IDLE.
REQ-024 SHALL: latency from detection cycle T: trap jump_en_o at T+4; MRET jump_en_o at T+2.
REQ-025 SHALL: hold_o=1 combinationally in the detection cycle and in every non-IDLE state, including JUMP; 0 otherwise.
REQ-026 SHALL: outside their active states csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, jump_en_o=0, jump_addr_o=0.
REQ-027 SHALL: irq_timer_i, ECALL and MRET inputs arriving while not in IDLE are ignored.
REQ-028 SHALL: EBREAK and all other instructions produce no action.

Reset
REQ-029 SHALL: rst=1 forces IDLE and clears captured pc, cause, snapshot, target immediately, regardless of clk.
REQ-030 SHALL: all outputs read 0 during reset; a sequence interrupted by reset is abandoned, not resumed.

Structure
REQ-031 SHALL: CSR addresses (0x300, 0x305, 0x341, 0x342), cause codes, ECALL/MRET encodings and mstatus bit indices live in the shared defines file.
REQ-032 SHALL: FSM state encoding is a local typedef; no sub-modules.

Verification
REQ-033 SHALL: ECALL at pc 0x8000_0010, mtvec 0x8000_0100, mstatus 0x8 -> writes 0x341=0x8000_0010, 0x342=11, 0x300=0x80 on T+1..T+3; jump to 0x8000_0100 at T+4; hold_o high T..T+4.
REQ-034 SHALL: MRET with mepc 0x8000_0014, mstatus 0x80 -> write 0x300=0x88 at T+1; jump to 0x8000_0014 at T+2.
REQ-035 SHALL: irq_timer_i=1, mstatus 0x8, mie 0x80, pc 0x8000_0020 -> mcause 0x8000_0000_0000_0007, mepc 0x8000_0020; with mie=0 -> no action.
REQ-036 SHALL: ECALL and irq same cycle -> mcause 11; irq still high afterwards with MIE=0 -> no second trap.
REQ-037 SHALL: rst asserted during WR_MCAUSE -> all outputs 0 immediately, no jump; next ECALL after release runs full sequence.
REQ-038 SHALL: mtvec 0x8000_0103 -> jump_addr_o 0x8000_0100.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared trap constants: CSR addresses, cause codes, system-instruction encodings,
// mstatus/mie bit positions and the mstatus rewrite helpers used on trap entry and MRET.
package trap_ctrl_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [63:0] CAUSE_ECALL_M   = 64'd11;
   localparam logic [63:0] CAUSE_TIMER_IRQ = 64'h8000_0000_0000_0007;

   localparam logic [31:0] INST_ECALL = 32'h0000_0073;
   localparam logic [31:0] INST_MRET  = 32'h3020_0073;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;

   function automatic logic [63:0] mstatus_on_trap(input logic [63:0] s);
      logic [63:0] r;
      r               = s;
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   function automatic logic [63:0] mstatus_on_mret(input logic [63:0] s);
      logic [63:0] r;
      r               = s;
      r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: serialises mepc/mcause/mstatus updates through one
// CSR write port, then issues a single-cycle redirect; stalls the pipeline throughout.
module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [63:0] inst_addr_i,
   input  logic        inst_valid_i,
   input  logic        irq_timer_i,
   input  logic [63:0] mstatus_i,
   input  logic [63:0] mtvec_i,
   input  logic [63:0] mepc_i,
   input  logic [63:0] mie_i,
   output logic        csr_we_o,
   output logic [11:0] csr_waddr_o,
   output logic [63:0] csr_wdata_o,
   output logic        hold_o,
   output logic        jump_en_o,
   output logic [63:0] jump_addr_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_MEPC,
      S_WR_MCAUSE,
      S_WR_MSTATUS,
      S_JUMP
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] cause_q, cause_d;
   logic [63:0] snap_q, snap_d;
   logic [63:0] target_q, target_d;
   logic        is_mret_q, is_mret_d;

   logic        ecall_det, mret_det, irq_det, any_det;
   logic [63:0] trap_vec;
   logic        unused_bits;

   assign ecall_det = inst_valid_i && (inst_i == INST_ECALL);
   assign mret_det  = inst_valid_i && (inst_i == INST_MRET);
   assign irq_det   = irq_timer_i && mstatus_i[MSTATUS_MIE] && mie_i[MIE_MTIE] && inst_valid_i;
   assign any_det   = ecall_det || mret_det || irq_det;
   assign trap_vec  = {mtvec_i[63:2], 2'b00};

   assign unused_bits = ^{mie_i[63:MIE_MTIE+1], mie_i[MIE_MTIE-1:0], mtvec_i[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         cause_q   <= '0;
         snap_q    <= '0;
         target_q  <= '0;
         is_mret_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cause_q   <= cause_d;
         snap_q    <= snap_d;
         target_q  <= target_d;
         is_mret_q <= is_mret_d;
      end
   end

   // Synchronous exceptions win over the timer interrupt; a losing interrupt is simply
   // re-sampled the next time the FSM sits in IDLE.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      snap_d    = snap_q;
      target_d  = target_q;
      is_mret_d = is_mret_q;
      case (state_q)
         S_IDLE: begin
            if (ecall_det) begin
               pc_d      = inst_addr_i;
               cause_d   = CAUSE_ECALL_M;
               snap_d    = mstatus_i;
               target_d  = trap_vec;
               is_mret_d = 1'b0;
               state_d   = S_WR_MEPC;
            end else if (mret_det) begin
               snap_d    = mstatus_i;
               target_d  = mepc_i;
               is_mret_d = 1'b1;
               state_d   = S_WR_MSTATUS;
            end else if (irq_det) begin
               pc_d      = inst_addr_i;
               cause_d   = CAUSE_TIMER_IRQ;
               snap_d    = mstatus_i;
               target_d  = trap_vec;
               is_mret_d = 1'b0;
               state_d   = S_WR_MEPC;
            end
         end
         S_WR_MEPC:    state_d = S_WR_MCAUSE;
         S_WR_MCAUSE:  state_d = S_WR_MSTATUS;
         S_WR_MSTATUS: state_d = S_JUMP;
         S_JUMP:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      jump_en_o   = 1'b0;
      jump_addr_o = '0;
      hold_o      = !rst && ((state_q != S_IDLE) || any_det);
      case (state_q)
         S_WR_MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = pc_q;
         end
         S_WR_MCAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         S_WR_MSTATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = is_mret_q ? mstatus_on_mret(snap_q) : mstatus_on_trap(snap_q);
         end
         S_JUMP: begin
            jump_en_o   = 1'b1;
            jump_addr_o = target_q;
         end
         default: ;
      endcase
   end

endmodule
